// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-cache address split.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ITAG_W  = 26;
  localparam int unsigned IIDX_W  = 4;
  localparam int unsigned IFRAMES = 16;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 16 one-word frames, single
// outstanding fill to the memory controller, saturating hit/miss counters.
module icache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  word_t       imemaddr,
  output logic        ihit,
  output word_t       imemload,
  output logic        iREN,
  output word_t       iaddr,
  input  logic        iwait,
  input  word_t       iload,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  typedef enum logic {StIdle, StFetch} state_e;

  state_e               state_q, state_d;
  icachef_t             miss_addr_q, miss_addr_d;
  logic [IFRAMES-1:0]   valid_q;
  logic [ITAG_W-1:0]    tag_q  [IFRAMES];
  word_t                data_q [IFRAMES];
  logic [15:0]          hit_cnt_q, miss_cnt_q;

  icachef_t req;
  logic     lookup_hit;
  logic     fill;

  assign req        = icachef_t'(imemaddr);
  assign lookup_hit = valid_q[req.idx] && (tag_q[req.idx] == req.tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    fill        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req.idx];
          end else begin
            miss_addr_d = req;
            state_d     = StFetch;
          end
        end
      end
      StFetch: begin
        // The fetch stage's current address is ignored here: the latched fill always completes.
        iREN  = 1'b1;
        iaddr = word_t'(miss_addr_q);
        if (!iwait) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill) begin
        valid_q[miss_addr_q.idx] <= 1'b1;
      end
      if (ihit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (fill && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  // Tag/data need no reset: the valid bits alone gate every lookup.
  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tag_q[miss_addr_q.idx]  <= miss_addr_q.tag;
      data_q[miss_addr_q.idx] <= iload;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle vector table plus hand-written
// reset-mid-fill and counter-saturation sequences.
module tb_icache;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  icache dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_ihit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic ren, logic [31:0] addr, logic wt, logic [31:0] ld,
                               logic e_ihit, logic [31:0] e_load, logic e_iren,
                               logic [31:0] e_iaddr);
    vec_t v;
    v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
    v.e_ihit = e_ihit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      imemREN  = vecs[i].ren;
      imemaddr = vecs[i].addr;
      iwait    = vecs[i].wt;
      iload    = vecs[i].ld;
      #2;
      chk($sformatf("v%0d.ihit", i),     {31'd0, ihit}, {31'd0, vecs[i].e_ihit});
      chk($sformatf("v%0d.imemload", i), imemload,      vecs[i].e_load);
      chk($sformatf("v%0d.iREN", i),     {31'd0, iREN}, {31'd0, vecs[i].e_iren});
      chk($sformatf("v%0d.iaddr", i),    iaddr,         vecs[i].e_iaddr);
      step();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;

    // Cold miss on 0x40: three wait cycles, then fill; first hit on the 6th cycle.
    vecs.push_back(mkv(1, 32'h40, 1, 32'h0,        0, 32'h0,        0, 32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1, 32'h40, 1, 32'h0,      0, 32'h0,        1, 32'h40));
    vecs.push_back(mkv(1, 32'h40, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mkv(1, 32'h40, 0, 32'h0,      1, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mkv(0, 32'h40, 0, 32'h0,        0, 32'h0,        0, 32'h0));
    // Conflict on idx 1: 0x04 / 0x44 / 0x04.
    vecs.push_back(mkv(1, 32'h04, 0, 32'h11111111, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 32'h11111111, 0, 32'h0,        1, 32'h04));
    vecs.push_back(mkv(1, 32'h04, 0, 32'h0,        1, 32'h11111111, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h44, 0, 32'h22222222, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mkv(1, 32'h44, 0, 32'h22222222, 0, 32'h0,        1, 32'h44));
    vecs.push_back(mkv(1, 32'h44, 0, 32'h0,        1, 32'h22222222, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 32'h11111111, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 32'h11111111, 0, 32'h0,        1, 32'h04));
    vecs.push_back(mkv(1, 32'h04, 0, 32'h0,        1, 32'h11111111, 0, 32'h0));
    // Address and request change mid-fill: 0x80 fill completes, then 0x100 misses.
    vecs.push_back(mkv(1, 32'h80,  1, 32'h0,        0, 32'h0,        0, 32'h0));
    vecs.push_back(mkv(1, 32'h100, 1, 32'h0,        0, 32'h0,        1, 32'h80));
    vecs.push_back(mkv(0, 32'h100, 0, 32'hAAAA5555, 0, 32'h0,        1, 32'h80));
    vecs.push_back(mkv(1, 32'h100, 0, 32'h12345678, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mkv(1, 32'h100, 0, 32'h12345678, 0, 32'h0,        1, 32'h100));
    vecs.push_back(mkv(1, 32'h100, 0, 32'h0,        1, 32'h12345678, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h80,  0, 32'hAAAA5555, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mkv(1, 32'h80,  0, 32'hAAAA5555, 0, 32'h0,        1, 32'h80));
    vecs.push_back(mkv(1, 32'h80,  0, 32'h0,        1, 32'hAAAA5555, 0, 32'h0));

    // Reset state.
    #2;
    chk("rst.ihit",     {31'd0, ihit}, 32'd0);
    chk("rst.imemload", imemload,      32'd0);
    chk("rst.iREN",     {31'd0, iREN}, 32'd0);
    chk("rst.iaddr",    iaddr,         32'd0);
    chk("rst.hit_cnt",  {16'd0, hit_cnt},  32'd0);
    chk("rst.miss_cnt", {16'd0, miss_cnt}, 32'd0);
    step();
    RST = 1'b0;

    run_vecs(0, 10);
    chk("cold.hit_cnt",  {16'd0, hit_cnt},  32'd6);
    chk("cold.miss_cnt", {16'd0, miss_cnt}, 32'd1);
    run_vecs(11, vecs.size() - 1);
    chk("table.hit_cnt",  {16'd0, hit_cnt},  32'd11);
    chk("table.miss_cnt", {16'd0, miss_cnt}, 32'd7);

    // Reset mid-FETCH: iREN drops at once and no frame is written.
    imemREN = 1'b1; imemaddr = 32'hC0; iwait = 1'b1; iload = 32'h0;
    step();
    #2;
    chk("rmf.iREN_before", {31'd0, iREN}, 32'd1);
    chk("rmf.iaddr_before", iaddr, 32'hC0);
    RST = 1'b1;
    #1;
    chk("rmf.iREN_async", {31'd0, iREN}, 32'd0);
    chk("rmf.iaddr_async", iaddr, 32'd0);
    chk("rmf.hit_cnt",  {16'd0, hit_cnt},  32'd0);
    chk("rmf.miss_cnt", {16'd0, miss_cnt}, 32'd0);
    iwait = 1'b0; iload = 32'h55555555;
    step();
    RST = 1'b0;
    iwait = 1'b1;
    #2;
    chk("rmf.no_hit_C0", {31'd0, ihit}, 32'd0);
    imemaddr = 32'h80;
    #1;
    chk("rmf.no_hit_80", {31'd0, ihit}, 32'd0);
    chk("rmf.load_zero", imemload, 32'd0);
    imemREN = 1'b0;
    do_reset();

    // Hit counter saturation.
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'hCAFEF00D;
    step();
    step();
    repeat (65534) step();
    chk("sat.hit_cnt_fffe", {16'd0, hit_cnt}, 32'h0000FFFE);
    step();
    chk("sat.hit_cnt_ffff", {16'd0, hit_cnt}, 32'h0000FFFF);
    repeat (5) step();
    chk("sat.hit_cnt_hold", {16'd0, hit_cnt}, 32'h0000FFFF);
    chk("sat.miss_cnt", {16'd0, miss_cnt}, 32'd1);
    chk("sat.ihit", {31'd0, ihit}, 32'd1);
    chk("sat.imemload", imemload, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have port CLK, input, 1, system clock, all state on rising edge.
REQ-002 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port imemREN, input, 1, fetch-stage read request.
REQ-004 SHALL have port imemaddr, input, word_t (32), fetch address, byte-addressed, word-aligned.
REQ-005 SHALL have port ihit, output, 1, imemload valid for imemaddr this cycle.
REQ-006 SHALL have port imemload, output, word_t, instruction returned to fetch stage.
REQ-007 SHALL have port iREN, output, 1, read request to memory controller.
REQ-008 SHALL have port iaddr, output, word_t, memory controller read address.
REQ-009 SHALL have port iwait, input, 1, memory controller busy; iload is valid in a cycle when iREN=1 and iwait=0.
REQ-010 SHALL have port iload, input, word_t, memory controller read data.
REQ-011 SHALL have port hit_cnt, output, 16, count of hit cycles, saturating.
REQ-012 SHALL have port miss_cnt, output, 16, count of completed fills, saturating.

Function
REQ-013 SHALL be direct-mapped with 16 one-word frames; imemaddr splits into tag[31:6], idx[5:2], bytoff[1:0], and bytoff is ignored.
REQ-014 SHALL give each frame a valid bit (1), tag (26) and data (word_t).
REQ-015 SHALL use a two-state FSM: IDLE and FETCH.
REQ-016 In IDLE, SHALL drive ihit=1 combinationally (zero latency) and imemload=frame[idx].data when imemREN=1 and the frame is valid with a matching tag.
REQ-017 In IDLE, when imemREN=1 and the lookup misses, SHALL latch imemaddr into miss_addr and move to FETCH on the next edge; ihit=0 that cycle.
REQ-018 In FETCH, SHALL drive iREN=1 and iaddr=miss_addr; ihit SHALL be 0 for the whole of FETCH.
REQ-019 In FETCH, when iwait=0, SHALL write frame[miss_addr.idx] with valid=1, the miss tag and iload, then return to IDLE; the first hit is therefore seen the cycle after the fill.
REQ-020 In FETCH with iwait=1, SHALL stay in FETCH and hold iREN and iaddr stable.
REQ-021 A change in imemaddr or imemREN during FETCH SHALL NOT abort the fill; the latched miss_addr fill SHALL always complete.
REQ-022 In IDLE, SHALL drive iREN=0 and iaddr=0.
REQ-023 When imemREN=0 or on a miss, SHALL drive imemload=0.
REQ-024 A fill SHALL overwrite a conflicting valid frame with no write-back, since the cache is read-only.
REQ-025 SHALL increment hit_cnt on each IDLE hit cycle and miss_cnt on each fill cycle, holding both at 16'hFFFF.
REQ-026 Miss-to-ihit latency SHALL be 2 + (number of FETCH cycles with iwait=1).

Reset
REQ-027 While RST=1, SHALL immediately and asynchronously force state to IDLE, clear all valid bits, and clear miss_addr, hit_cnt and miss_cnt.
REQ-028 Reset values SHALL be ihit=0, imemload=0, iREN=0, iaddr=0, hit_cnt=0 and miss_cnt=0.
REQ-029 RST asserted mid-FETCH SHALL abandon the fill, write no frame, and drop iREN in the same cycle.

Structure
REQ-030 SHALL place an icachef_t packed struct (tag 26, idx 4, bytoff 2) and the constants ITAG_W=26, IIDX_W=4 and IFRAMES=16 in cpu_types_pkg.
REQ-031 SHALL hold the frame array as flops inside icache, with no sub-module.
REQ-032 SHALL declare the FSM state as a local enum in icache.

Verification
REQ-033 Cold miss: RST pulse, then imemREN=1, imemaddr=0x00000040, with iwait=1 for 3 cycles and then 0 with iload=0xDEADBEEF -> iREN=1 with iaddr=0x40 for 4 cycles, ihit=1 with imemload=0xDEADBEEF at cycle 6, miss_cnt=1.
REQ-034 Repeat hit: 0x40 held for 5 more cycles -> ihit=1 every cycle, iREN=0, hit_cnt increments by 5.
REQ-035 Conflict: fill 0x00000004 (0x11111111), then 0x00000044 (0x22222222), then 0x04 again -> third access misses and refetches 0x11111111, miss_cnt=3.
REQ-036 Address change mid-fill: miss on 0x80, then imemaddr switches to 0x100 during FETCH -> iaddr stays 0x80, frame 0 is filled with tag(0x80), then 0x100 misses.
REQ-037 Reset mid-FETCH: RST asserted while iwait=1 -> iREN=0 in the same cycle, the address does not hit afterwards, and both counters are 0.
REQ-038 Saturation: force 65536+ hit cycles -> hit_cnt holds at 0xFFFF with no wrap.
